// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, decoder handshake and the redirect/halt controls.
// master = fetch_unit, slave = memory/decoder side.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fetch_misaligned;

    modport master (
        output imem_req, imem_addr, ir_valid, ir, ir_pc, fetch_misaligned,
        input  imem_gnt, imem_rvalid, imem_rdata, ir_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir, ir_pc, fetch_misaligned,
        output imem_gnt, imem_rvalid, imem_rdata, ir_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem word requests and delivers returned words in order.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect target traps into a sticky FAULT state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DROP_W = 8;

    typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

    state_t state, state_next;

    logic [31:0]           pc;
    logic [31:0]           slot_data [FIFO_DEPTH];
    logic [31:0]           slot_pc   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_filled;
    logic [PTR_W-1:0]      head, tail, fill;
    logic [CNT_W-1:0]      count, outstanding, outstanding_left;
    logic [DROP_W-1:0]     drop, drop_left;
    logic                  running, pop, grant, accept, discard, flush, bad_redirect;

    // A slot freed by this cycle's pop may be re-requested at once, which keeps 1 instr/cycle at depth 2.
    always_comb begin
        running      = (state == RUN);
        bus.ir_valid = running && slot_filled[head];
        bus.ir       = slot_data[head];
        bus.ir_pc    = slot_pc[head];
        pop          = bus.ir_valid && bus.ir_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
        bad_redirect = running && bus.redirect && !bus.halt && (bus.redirect_pc[1:0] != 2'b00);
`else
        bad_redirect = 1'b0;
`endif
        flush         = running && (bus.redirect || bus.halt);
        bus.imem_req  = rst_n && running && !flush &&
                        ((count - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH));
        bus.imem_addr = pc;
        grant         = bus.imem_req && bus.imem_gnt;
        discard       = bus.imem_rvalid && (drop != '0);
        accept        = bus.imem_rvalid && (drop == '0) && (outstanding != '0);
        drop_left        = drop - DROP_W'(discard);
        outstanding_left = outstanding - CNT_W'(accept);
    end

    always_comb begin
        state_next = state;
        if (state == RUN) begin
            if (bus.halt) begin
                state_next = HALTED;
            end else if (bad_redirect) begin
                state_next = FAULT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // On a flush every request still in flight becomes a response to throw away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            slot_filled <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot_data[i] <= '0;
                slot_pc[i]   <= '0;
            end
        end else if (flush) begin
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            count       <= '0;
            outstanding <= '0;
            slot_filled <= '0;
            drop        <= drop_left + DROP_W'(outstanding_left);
            if (bus.redirect && !bus.halt && !bad_redirect) begin
                pc <= bus.redirect_pc & 32'hFFFF_FFFC;
            end
        end else begin
            drop        <= drop_left;
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(accept);
            count       <= count + CNT_W'(grant) - CNT_W'(pop);
            if (pop) begin
                slot_filled[head] <= 1'b0;
                head              <= head + PTR_W'(1);
            end
            if (grant) begin
                slot_pc[tail]     <= pc;
                slot_filled[tail] <= 1'b0;
                tail              <= tail + PTR_W'(1);
                pc                <= pc + 32'd4;
            end
            if (accept) begin
                slot_data[fill]   <= bus.imem_rdata;
                slot_filled[fill] <= 1'b1;
                fill              <= fill + PTR_W'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned <= 1'b0;
        end else if (bad_redirect) begin
            misaligned <= 1'b1;
        end
    end

    assign bus.fetch_misaligned = misaligned;
`else
    assign bus.fetch_misaligned = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: an in-order imem responder with selectable latency,
// directed phases push the instructions they expect and a monitor checks every ir handshake.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } instr_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mem_rsp_t;

    instr_t   sb_q[$];
    mem_rsp_t mem_q[$];
    int       edge_cnt = 0;
    int       mem_lat  = 1;
    int       n_checks = 0;
    int       n_fail   = 0;
    logic     exp_req;
    logic     exp_flag;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic gnt, input logic redir,
                                 input logic [31:0] rpc, input logic hlt);
        bus.ir_ready    = rdy;
        bus.imem_gnt    = gnt;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.halt        = hlt;
    endtask

    task automatic expectInstr(input logic [31:0] pc);
        sb_q.push_back('{pc: pc, word: word_at(pc)});
    endtask

    task automatic checkDrain(input string name);
        checkOutput({name, "_sb_drain"}, 32'(sb_q.size()), 32'd0);
    endtask

    // Called at a falling edge; returns at the falling edge that starts the first cycle after reset.
    task automatic applyReset(input int lat);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        checkOutput("rst_ir", bus.ir, 32'd0);
        checkOutput("rst_ir_pc", bus.ir_pc, 32'd0);
        checkOutput("rst_misaligned", 32'(bus.fetch_misaligned), 32'd0);
        @(negedge clk);
        mem_lat = lat;
        rst_n   = 1'b1;
    endtask

    // Memory side, grant bookkeeping: sampled on the rising edge with pre-edge values.
    initial forever begin
        @(posedge clk);
        edge_cnt++;
        if (!rst_n) begin
            mem_q.delete();
        end else begin
            if (bus.imem_rvalid && mem_q.size() > 0) begin
                mem_q.delete(0);
            end
            if (bus.imem_req && bus.imem_gnt) begin
                mem_q.push_back('{due: edge_cnt + mem_lat, addr: bus.imem_addr});
            end
        end
    end

    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_q.size() > 0 && mem_q[0].due == edge_cnt + 1) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = word_at(mem_q[0].addr);
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = '0;
            end
        end
    end

    // Monitor: every accepted instruction must be the next one the stimulus expected.
    initial forever begin
        @(posedge clk);
        if (rst_n && bus.ir_valid && bus.ir_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_ir_valid", 32'(bus.ir_valid), 32'd0);
            end else begin
                instr_t exp_i;
                exp_i = sb_q.pop_front();
                checkOutput("sb_ir_pc", bus.ir_pc, exp_i.pc);
                checkOutput("sb_ir", bus.ir, exp_i.word);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyReset(1);

        // Streaming: 1-cycle imem, always granted and ready.
        for (int i = 0; i < 8; i++) expectInstr(32'(4 * i));
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            #1;
            checkOutput("p1_req", 32'(bus.imem_req), 32'd1);
            checkOutput("p1_addr", bus.imem_addr, 32'(4 * (c - 1)));
            checkOutput("p1_ir_valid", 32'(bus.ir_valid), (c >= 3) ? 32'd1 : 32'd0);
            if (c >= 3) checkOutput("p1_ir_pc", bus.ir_pc, 32'(4 * (c - 3)));
            @(negedge clk);
        end
        checkDrain("p1");

        // Decoder stall for 5 cycles, then resume.
        applyReset(1);
        for (int i = 0; i < 7; i++) expectInstr(32'(4 * i));
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(c >= 6, 1'b1, 1'b0, 32'h0, 1'b0);
            #1;
            if (c <= 2) checkOutput("p2_fill_req", 32'(bus.imem_req), 32'd1);
            if (c >= 3 && c <= 5) begin
                checkOutput("p2_stall_req", 32'(bus.imem_req), 32'd0);
                checkOutput("p2_stall_ir_pc", bus.ir_pc, 32'h0);
                checkOutput("p2_stall_ir", bus.ir, word_at(32'h0));
            end
            if (c == 6) checkOutput("p2_resume_addr", bus.imem_addr, 32'h8);
            @(negedge clk);
        end
        checkDrain("p2");

        // PC wrap at the top of the address space.
        applyReset(1);
        expectInstr(32'hFFFF_FFFC);
        expectInstr(32'h0000_0000);
        expectInstr(32'h0000_0004);
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(1'b1, 1'b1, c == 1, 32'hFFFF_FFFC, 1'b0);
            #1;
            case (c)
                1: checkOutput("p5_redirect_req", 32'(bus.imem_req), 32'd0);
                2: checkOutput("p5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
                3: checkOutput("p5_addr_wrap", bus.imem_addr, 32'h0000_0000);
                4: checkOutput("p5_ir_pc_top", bus.ir_pc, 32'hFFFF_FFFC);
                default: ;
            endcase
            @(negedge clk);
        end
        checkDrain("p5");

        // Redirect with two requests in flight on a 3-cycle imem.
        applyReset(3);
        expectInstr(32'h100);
        expectInstr(32'h104);
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(1'b1, 1'b1, c == 3, 32'h100, 1'b0);
            #1;
            case (c)
                2: checkOutput("p3_second_addr", bus.imem_addr, 32'h4);
                3: checkOutput("p3_redirect_req", 32'(bus.imem_req), 32'd0);
                4: checkOutput("p3_new_addr", bus.imem_addr, 32'h100);
                5, 6, 7: checkOutput("p3_flushed_ir_valid", 32'(bus.ir_valid), 32'd0);
                8: checkOutput("p3_first_ir_pc", bus.ir_pc, 32'h100);
                default: ;
            endcase
            @(negedge clk);
        end
        checkDrain("p3");

        // Redirect to a misaligned target.
        applyReset(1);
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_req  = 1'b0;
        exp_flag = 1'b1;
`else
        exp_req  = 1'b1;
        exp_flag = 1'b0;
        expectInstr(32'h100);
        expectInstr(32'h104);
`endif
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(1'b1, 1'b1, c == 1, 32'h102, 1'b0);
            #1;
            if (c >= 2) begin
                checkOutput("p6_req", 32'(bus.imem_req), 32'(exp_req));
                checkOutput("p6_misaligned", 32'(bus.fetch_misaligned), 32'(exp_flag));
            end
            if (c == 2 && exp_req) checkOutput("p6_aligned_addr", bus.imem_addr, 32'h100);
            @(negedge clk);
        end
        checkDrain("p6");

        // Halt with one request outstanding; a later redirect must not wake the unit.
        applyReset(3);
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(1'b1, 1'b1, c == 6, 32'h200, c == 2);
            #1;
            if (c == 1) checkOutput("p4_first_addr", bus.imem_addr, 32'h0);
            if (c >= 3) begin
                checkOutput("p4_halted_req", 32'(bus.imem_req), 32'd0);
                checkOutput("p4_halted_ir_valid", 32'(bus.ir_valid), 32'd0);
            end
            @(negedge clk);
        end
        checkDrain("p4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
